// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial transmit path.
//   tx_state_t           - transmitter FSM states
//   DATA_BITS/FRAME_BITS - 8N1 framing constants
//   DEFAULT_CLKS_PER_BIT - 115200 baud from a 100 MHz clock
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS           = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Baud counter is wide enough for the largest legal CLKS_PER_BIT (65535).
  localparam int BAUD_CNT_W = 16;
  localparam int BIT_CNT_W  = $clog2(DATA_BITS);

endpackage

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: byte FIFO feeding the serial transmitter.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous reset, active low; empties the FIFO
//   push      - write strobe, ignored while full or in reset
//   push_data - byte to write
//   pop       - read strobe, ignored while empty
//   pop_data  - head of the FIFO (valid while empty=0)
//   full      - FIFO_DEPTH bytes held (decoded from the count register)
//   empty     - no bytes held (decoded from the count register)
module serial_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty = (count_reg == '0);

  assign do_push = push && !full && rst;
  assign do_pop  = pop && !empty;

  // The transmitter loads its shift register on the same edge it pops, so
  // the head entry is read combinationally. Depth is tiny (<= 16 entries).
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers are exactly log2(FIFO_DEPTH) bits wide, so they wrap for free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter with a small input FIFO.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous reset, active low; aborts any frame, flushes queue
//   dat_t - byte to transmit, sampled when txe=1
//   txe   - write strobe; one byte offered per cycle high (dropped if full)
//   full  - FIFO holds FIFO_DEPTH bytes
//   busy  - bytes queued or a frame on the line (registered)
//   tx    - serial line, idle high, LSB first (registered)
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dat_t,
  input  logic       txe,
  output logic       full,
  output logic       busy,
  output logic       tx
);

  tx_state_t             state_reg, state_next;
  logic [BAUD_CNT_W-1:0] baud_reg, baud_next;
  logic [BIT_CNT_W-1:0]  bit_reg, bit_next;
  logic [7:0]            shift_reg, shift_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;

  logic                  fifo_pop;
  logic [7:0]            fifo_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  baud_last;

  serial_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (txe),
    .push_data (dat_t),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign baud_last = (baud_reg == BAUD_CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    fifo_pop   = 1'b0;

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_data;
          state_next = START;
        end
      end

      START: begin
        if (baud_last) begin
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == BIT_CNT_W'(DATA_BITS - 1)) begin
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_next = '0;
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_data;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The line and busy flag are registered from the current state, so they
  // trail the FSM by one cycle: a pop at edge N shows as a start bit from
  // edge N+1, and busy drops on the same edge the stop bit finishes.
  always_comb begin
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_reg != IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
    end
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;
  assign full = fifo_full;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: self-checking bench for serial_tx (CLKS_PER_BIT=4, depth 4).
// A line monitor decodes 8N1 frames from tx into rx_q; each test pushes the
// bytes it expects onto exp_q and compares the two queues afterwards.
module tb_serial_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       txe   = 1'b0;
  logic [7:0] dat_t = 8'h00;
  logic       full;
  logic       busy;
  logic       tx;

  serial_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .dat_t (dat_t),
    .txe   (txe),
    .full  (full),
    .busy  (busy),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int frame_err = 0;
  int mon_phase = -1;
  logic [7:0] mon_shift = 8'h00;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         start_q[$];

  // cyc = number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: samples tx mid-bit, phase counted from the edge the start bit appears.
  always begin
    @(posedge clk);
    #1;
    if (rst === 1'b0) begin
      mon_phase = -1;
    end else if (mon_phase < 0) begin
      if (tx === 1'b0) begin
        mon_phase = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_phase++;
      if (mon_phase == CPB / 2) begin
        if (tx !== 1'b0) begin
          frame_err++;
          mon_phase = -1;
        end
      end else if (mon_phase > CPB / 2 && mon_phase <= CPB / 2 + 8 * CPB &&
                   (mon_phase - CPB / 2) % CPB == 0) begin
        mon_shift = {tx, mon_shift[7:1]};
      end else if (mon_phase == CPB / 2 + 9 * CPB) begin
        if (tx !== 1'b1) frame_err++;
        rx_q.push_back(mon_shift);
        mon_phase = -1;
      end
    end
  end

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Called at a negedge; the byte is written on the following rising edge.
  task automatic offer(input logic [7:0] d);
    txe   = 1'b1;
    dat_t = d;
    @(negedge clk);
    txe = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    int lim;
    lim = 0;
    repeat (2) @(negedge clk);
    while ((busy !== 1'b0 || mon_phase >= 0) && lim < 2000) begin
      @(negedge clk);
      lim++;
    end
    timed_out = (lim >= 2000);
  endtask

  task automatic test_reset();
    bit to;
    int e;
    logic [7:0] ev, rv;
    rst   = 1'b0;
    txe   = 1'b1;
    dat_t = 8'h77;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    exp_q.delete(); rx_q.delete(); start_q.delete();
    // First edge with rst=1 accepts the write; the byte held during reset is not sent.
    rst   = 1'b1;
    dat_t = 8'hC3;
    e = cyc + 1;
    @(negedge clk);
    txe = 1'b0;
    exp_q.push_back(8'hC3);
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL reset_drain: timed out waiting for idle"); end
    n_checks++;
    if (start_q.size() != 1 || start_q[0] != e + 2) begin
      n_fail++;
      $display("FAIL reset_first_write: got %0d starts (first at %0d) expected 1 at %0d",
               start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, e + 2);
    end
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL reset_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = rx_q.pop_front();
      n_checks++; if (rv !== ev) begin n_fail++; $display("FAIL reset_byte: got %02h expected %02h", rv, ev); end
    end
    exp_q.delete(); rx_q.delete();
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit to;
    int n;
    logic [9:0] fr;
    logic [7:0] ev, rv;
    start_q.delete();
    fr = {1'b1, 8'h55, 1'b0};
    n = cyc + 1;
    offer(8'h55);
    exp_q.push_back(8'h55);
    wait_until(n + 1);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_latency: tx got %b at N+1 expected 1", tx); end
    for (int k = 0; k < 10; k++) begin
      wait_until(n + 2 + k * CPB + CPB / 2);
      n_checks++;
      if (tx !== fr[k]) begin n_fail++; $display("FAIL single_bit%0d: got %b expected %b", k, tx, fr[k]); end
    end
    wait_until(n + 41);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_hold: got %b expected 1", busy); end
    wait_until(n + 42);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL single_drain: timed out waiting for idle"); end
    n_checks++;
    if (start_q.size() < 1 || start_q[0] != n + 2) begin
      n_fail++; $display("FAIL single_start: got %0d expected %0d", (start_q.size() > 0) ? start_q[0] : -1, n + 2);
    end
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = rx_q.pop_front();
      n_checks++; if (rv !== ev) begin n_fail++; $display("FAIL single_byte: got %02h expected %02h", rv, ev); end
    end
    exp_q.delete(); rx_q.delete();
    $display("test_single done: byte 55");
  endtask

  task automatic test_back_to_back();
    bit to;
    int n;
    logic [7:0] ev, rv;
    start_q.delete();
    n = cyc + 1;
    offer(8'hA5); exp_q.push_back(8'hA5);
    offer(8'h3C); exp_q.push_back(8'h3C);
    wait_until(n + 81);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_hold: got %b expected 1", busy); end
    wait_until(n + 82);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_fall: got %b expected 0", busy); end
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_drain: timed out waiting for idle"); end
    n_checks++;
    if (start_q.size() != 2 || start_q[0] != n + 2 || start_q[1] != n + 42) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d starts at %0d,%0d expected 2 at %0d,%0d", start_q.size(),
               (start_q.size() > 0) ? start_q[0] : -1, (start_q.size() > 1) ? start_q[1] : -1, n + 2, n + 42);
    end
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = rx_q.pop_front();
      n_checks++; if (rv !== ev) begin n_fail++; $display("FAIL b2b_byte: got %02h expected %02h", rv, ev); end
    end
    exp_q.delete(); rx_q.delete();
    $display("test_back_to_back done: bytes A5 3C");
  endtask

  task automatic test_fifo_full();
    bit to;
    int model_cnt;
    bit acc;
    logic [7:0] d, ev, rv;
    model_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      d   = 8'(i + 1);
      acc = (model_cnt < DEPTH);
      txe   = 1'b1;
      dat_t = d;
      @(negedge clk);
      if (acc) begin exp_q.push_back(d); model_cnt++; end
      // The idle FSM pops the first byte on the edge after it was written.
      if (i == 1) model_cnt--;
      n_checks++;
      if (full !== (model_cnt == DEPTH)) begin
        n_fail++; $display("FAIL full_flag_w%0d: got %b expected %b", i, full, (model_cnt == DEPTH));
      end
    end
    txe = 1'b0;
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL full_drain: timed out waiting for idle"); end
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = rx_q.pop_front();
      n_checks++; if (rv !== ev) begin n_fail++; $display("FAIL full_byte: got %02h expected %02h", rv, ev); end
    end
    exp_q.delete(); rx_q.delete();
    $display("test_fifo_full done: 6 offered, 5 expected");
  endtask

  task automatic test_write_on_pop();
    bit to;
    int m;
    logic [7:0] ev, rv;
    start_q.delete();
    m = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      offer(8'(8'h10 * (i + 1)));
      exp_q.push_back(8'(8'h10 * (i + 1)));
    end
    // Frame 1 popped at m+1; its STOP pops the next byte at m+41 with 3 queued.
    wait_until(m + 40);
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL wop_pre_full: got %b expected 0", full); end
    txe = 1'b1; dat_t = 8'h50;
    @(negedge clk);
    exp_q.push_back(8'h50);
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL wop_same_edge_full: got %b expected 0", full); end
    dat_t = 8'h60;
    @(negedge clk);
    txe = 1'b0;
    exp_q.push_back(8'h60);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL wop_next_full: got %b expected 1", full); end
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL wop_drain: timed out waiting for idle"); end
    n_checks++;
    if (start_q.size() < 2 || start_q[1] != m + 42) begin
      n_fail++; $display("FAIL wop_chain: second start got %0d expected %0d", (start_q.size() > 1) ? start_q[1] : -1, m + 42);
    end
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wop_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = rx_q.pop_front();
      n_checks++; if (rv !== ev) begin n_fail++; $display("FAIL wop_byte: got %02h expected %02h", rv, ev); end
    end
    exp_q.delete(); rx_q.delete();
    $display("test_write_on_pop done: 6 bytes");
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    int n, n2, lows, busys;
    logic [7:0] ev, rv;
    start_q.delete();
    n = cyc + 1;
    offer(8'hFF); offer(8'h11); offer(8'h22);
    wait_until(n + 18);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_bit3: got %b expected 1", tx); end
    rst = 1'b0; txe = 1'b1; dat_t = 8'h99;
    @(negedge clk);
    n_checks++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL mid_rst_tx: got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL mid_rst_full: got %b expected 0", full); end
    @(negedge clk);
    rst = 1'b1; txe = 1'b0;
    lows = 0; busys = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    n_checks++; if (lows != 0)  begin n_fail++; $display("FAIL mid_quiet_tx: got %0d low cycles expected 0", lows); end
    n_checks++; if (busys != 0) begin n_fail++; $display("FAIL mid_quiet_busy: got %0d busy cycles expected 0", busys); end
    n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL mid_no_frames: got %0d bytes expected 0", rx_q.size()); end
    rx_q.delete();
    n2 = cyc + 1;
    offer(8'h5A); exp_q.push_back(8'h5A);
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL mid_drain: timed out waiting for idle"); end
    n_checks++;
    if (start_q.size() != 2 || start_q[1] != n2 + 2) begin
      n_fail++; $display("FAIL mid_restart: got %0d starts (last %0d) expected 2 (last %0d)", start_q.size(),
                         (start_q.size() > 0) ? start_q[start_q.size() - 1] : -1, n2 + 2);
    end
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = rx_q.pop_front();
      n_checks++; if (rv !== ev) begin n_fail++; $display("FAIL mid_byte: got %02h expected %02h", rv, ev); end
    end
    exp_q.delete(); rx_q.delete();
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_loopback();
    bit to;
    int sent, guard;
    logic [7:0] d, ev, rv;
    frame_err = 0;
    sent = 0; guard = 0;
    while (sent < 256 && guard < 20000) begin
      if (full === 1'b0) begin
        d = 8'($urandom_range(0, 255));
        txe = 1'b1; dat_t = d;
        exp_q.push_back(d);
        sent++;
      end else begin
        txe = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    txe = 1'b0;
    n_checks++; if (sent != 256) begin n_fail++; $display("FAIL loop_send: got %0d sent expected 256", sent); end
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL loop_drain: timed out waiting for idle"); end
    n_checks++; if (frame_err != 0) begin n_fail++; $display("FAIL loop_framing: got %0d errors expected 0", frame_err); end
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL loop_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      ev = exp_q.pop_front(); rv = rx_q.pop_front();
      n_checks++; if (rv !== ev) begin n_fail++; $display("FAIL loop_byte: got %02h expected %02h", rv, ev); end
    end
    exp_q.delete(); rx_q.delete();
    $display("test_loopback done: %0d bytes", sent);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_write_on_pop();
    test_reset_mid_frame();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 200000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, is the number of clk cycles per serial bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, is the number of queued bytes; it SHALL be a power of two, 2..16.
REQ-003 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 dat_t  input  8  byte to transmit, sampled when txe=1.
REQ-006 txe  input  1  write strobe; one byte is offered per cycle it is high.
REQ-007 full  output  1  registered; FIFO holds FIFO_DEPTH bytes.
REQ-008 busy  output  1  registered; FIFO non-empty or a frame is in progress.
REQ-009 tx  output  1  registered serial line; 8N1 framing, LSB first, idle high.

Function
REQ-010 Frame format SHALL be start bit (0), data bits d0..d7, stop bit (1); each bit held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE with FIFO non-empty: pop head into shift register, go to START; tx SHALL be 0 from the next edge.
REQ-013 START -> DATA after CLKS_PER_BIT cycles; DATA shifts right every CLKS_PER_BIT cycles; DATA -> STOP after the 8th bit.
REQ-014 STOP, last cycle: if FIFO non-empty, pop and go directly to START (zero idle gap between frames); else go to IDLE.
REQ-015 Write latency: txe at edge N into empty FIFO while IDLE SHALL make tx fall at edge N+2 (FIFO write at N, pop at N+1).
REQ-016 txe while full=1 SHALL be ignored; the byte is dropped and FIFO contents are unchanged.
REQ-017 Simultaneous write and pop with full=0 SHALL both occur; count unchanged; no write-to-pop bypass.
REQ-018 FIFO count SHALL be log2(FIFO_DEPTH)+1 bits; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; bit counter SHALL count 0..7.
REQ-020 full and busy SHALL reflect state after each edge (no combinational path from txe).
REQ-021 Bytes SHALL be transmitted in write order, none duplicated or reordered.

Reset
REQ-022 rst=0 at an edge SHALL force: state IDLE, tx=1, full=0, busy=0, FIFO empty, all counters 0.
REQ-023 Reset mid-frame SHALL abort the frame; tx=1 from that edge; queued bytes are discarded.
REQ-024 txe during reset SHALL be ignored.
REQ-025 First write is accepted on the first edge with rst=1.

Structure
REQ-026 Package serial_pkg SHALL hold the FSM state enum, the 8N1 frame constants (data bits 8, frame bits 10), and default CLKS_PER_BIT.
REQ-027 The FIFO SHALL be a separate sub-module serial_tx_fifo (parameter FIFO_DEPTH, 8-bit data, push/pop/full/empty); serial_tx holds the FSM, baud counter, and shift register.
REQ-028 serial_tx's port names SHALL match the transmit side of module serial, so it drops in for loopback tests.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Single byte 0x55 written at edge N -> tx low at N+2; bits 1,0,1,0,1,0,1,0 each 4 cycles; stop high; busy low at N+42.
REQ-030 Bytes 0xA5, 0x3C written back-to-back -> two 40-cycle frames with no idle between them; data LSB first; busy falls after 80 cycles of line activity.
REQ-031 Six consecutive writes 0x01..0x06 while IDLE -> full asserts once 4 bytes are queued; the write offered while full is dropped; the received bytes match the accepted sequence in order.
REQ-032 Write on the same edge that STOP pops with FIFO full-1 -> count unchanged, full stays 0, no byte lost.
REQ-033 rst=0 during data bit 3 of 0xFF with 2 bytes queued -> tx=1, busy=0, full=0 next edge; no further frames until a new write.
REQ-034 Loopback via module serial's receiver: 256 random bytes -> every byte received equals the byte sent, with 0 framing errors.
